// File: rtl/pixel_array_readout_pkg.sv
// Shared configuration for the pixel array readout slice.
// Holds the default array geometry, the readout FSM state type, the pixel
// type and a small helper for index widths that stays legal for size 1.
package pixel_array_readout_pkg;

    localparam int PIXEL_ARRAY_HEIGHT = 4;
    localparam int PIXEL_ARRAY_WIDTH  = 4;
    localparam int PIXEL_BITS         = 8;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        CAPTURE,
        STREAM,
        FINISH
    } readout_state_t;

    typedef logic [PIXEL_BITS-1:0] pixel_t;

    // Width of an index into n items; never 0 so ports stay declarable.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pixel_array_readout_if.sv
// Pixel stream interface between the readout controller and its sink.
//   valid : beat valid (driven by master)
//   ready : sink accepts beat (driven by slave)
//   data  : pixel value
//   row   : row index of the beat
//   col   : column index of the beat
//   last  : final beat of the frame
// Handshake: a beat transfers on a rising clock edge where valid && ready.
// Once valid is raised, valid and every payload field stay unchanged until
// that transfer; ready may change freely and never depends on valid.
interface pixel_array_readout_if #(
    parameter int BITS  = 8,
    parameter int ROW_W = 2,
    parameter int COL_W = 2
);
    logic             valid;
    logic             ready;
    logic [BITS-1:0]  data;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic             last;

    modport master (output valid, data, row, col, last, input ready);
    modport slave  (input valid, data, row, col, last, output ready);
endinterface

// File: rtl/pixel_row_capture.sv
// Row buffer for the readout controller.
//   clk     : system clock
//   load    : when high, the whole column bus is registered into the buffer
//   data_in : column bus from the array, WIDTH pixels of BITS each
//   col     : column select for the output mux
//   pix     : buffered pixel at column col
// The buffer has no reset; its contents are only read after a load.
module pixel_row_capture #(
    parameter int WIDTH = 4,
    parameter int BITS  = 8,
    parameter int COL_W = 2
) (
    input  logic                        clk,
    input  logic                        load,
    input  logic [WIDTH-1:0][BITS-1:0]  data_in,
    input  logic [COL_W-1:0]            col,
    output logic [BITS-1:0]             pix
);

    logic [WIDTH-1:0][BITS-1:0] buffer;

    always_ff @(posedge clk) begin
        if (load) begin
            buffer <= data_in;
        end
    end

    assign pix = buffer[col];

endmodule

// File: rtl/pixel_array_readout.sv
// Row-sequenced readout controller for the pixel array.
// Selects one row at a time with a one-hot read line, lets the shared column
// bus settle, captures the row into a local buffer and streams it one pixel
// per beat. Supports a row window (first..last) and row subsampling.
//   clk       : system clock, rising edge
//   reset     : synchronous, active-high
//   start     : frame start pulse, only honoured in IDLE
//   row_first : first row of the window, sampled on start
//   row_last  : last row of the window, sampled on start (clamped to HEIGHT-1)
//   read      : one-hot row select to the array, 0 when not selecting
//   data_in   : column bus from the array
//   pix       : pixel stream (master side)
//   busy      : high from start accept until the frame completes
//   done      : one-cycle pulse at frame end
//   state_dbg : current FSM state
module pixel_array_readout
    import pixel_array_readout_pkg::*;
#(
    parameter int HEIGHT        = PIXEL_ARRAY_HEIGHT,
    parameter int WIDTH         = PIXEL_ARRAY_WIDTH,
    parameter int BITS          = PIXEL_BITS,
    parameter int SETTLE_CYCLES = 2,
    parameter int ROW_STEP      = 1,
    localparam int ROW_W        = idx_bits(HEIGHT),
    localparam int COL_W        = idx_bits(WIDTH)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [ROW_W-1:0]            row_first,
    input  logic [ROW_W-1:0]            row_last,
    output logic [HEIGHT-1:0]           read,
    input  logic [WIDTH-1:0][BITS-1:0]  data_in,
    pixel_array_readout_if.master       pix,
    output logic                        busy,
    output logic                        done,
    output readout_state_t              state_dbg
);

    localparam int CNT_W = idx_bits(SETTLE_CYCLES + 1);

    readout_state_t   state;
    logic [ROW_W-1:0] row_q;
    logic [ROW_W-1:0] last_q;
    logic [COL_W-1:0] col_q;
    logic [CNT_W-1:0] cnt_q;
    logic             valid_q;
    logic             last_beat_q;
    logic [BITS-1:0]  pix_mux;
    logic [ROW_W:0]   row_next;
    logic             final_row;
    logic             load;

    // One extra bit so row + step never wraps back into the window.
    assign row_next  = {1'b0, row_q} + (ROW_W+1)'(ROW_STEP);
    assign final_row = (row_next > {1'b0, last_q});
    assign load      = (state == CAPTURE);

    pixel_row_capture #(
        .WIDTH (WIDTH),
        .BITS  (BITS),
        .COL_W (COL_W)
    ) u_capture (
        .clk     (clk),
        .load    (load),
        .data_in (data_in),
        .col     (col_q),
        .pix     (pix_mux)
    );

    // read is registered one cycle behind the SELECT entry, so the first
    // SELECT cycle has read low and SELECT lasts SETTLE_CYCLES+1 cycles. The
    // row is then visible for SETTLE_CYCLES cycles before CAPTURE plus the
    // CAPTURE cycle itself, and the buffer samples at the end of CAPTURE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            row_q       <= '0;
            last_q      <= '0;
            col_q       <= '0;
            cnt_q       <= '0;
            read        <= '0;
            valid_q     <= 1'b0;
            last_beat_q <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        row_q  <= row_first;
                        last_q <= (int'(row_last) >= HEIGHT) ? ROW_W'(HEIGHT - 1) : row_last;
                        cnt_q  <= '0;
                        busy   <= 1'b1;
                        state  <= SELECT;
                    end
                end
                SELECT: begin
                    // Only the first row can lie outside the window (empty window).
                    if (row_q > last_q) begin
                        read  <= '0;
                        state <= FINISH;
                    end else begin
                        read <= HEIGHT'(1) << row_q;
                        if (cnt_q == CNT_W'(SETTLE_CYCLES)) begin
                            state <= CAPTURE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                CAPTURE: begin
                    read        <= '0;
                    valid_q     <= 1'b1;
                    col_q       <= '0;
                    last_beat_q <= (WIDTH == 1) && final_row;
                    state       <= STREAM;
                end
                STREAM: begin
                    if (valid_q && pix.ready) begin
                        if (int'(col_q) == WIDTH - 1) begin
                            valid_q     <= 1'b0;
                            last_beat_q <= 1'b0;
                            if (final_row) begin
                                state <= FINISH;
                            end else begin
                                row_q <= row_next[ROW_W-1:0];
                                cnt_q <= '0;
                                state <= SELECT;
                            end
                        end else begin
                            col_q       <= col_q + 1'b1;
                            last_beat_q <= (int'(col_q) + 2 == WIDTH) && final_row;
                        end
                    end
                end
                FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign pix.valid = valid_q;
    assign pix.data  = valid_q ? pix_mux : '0;
    assign pix.row   = row_q;
    assign pix.col   = col_q;
    assign pix.last  = last_beat_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_pixel_array_readout.sv
// Bench for pixel_array_readout. Three instances share clock and reset:
// dut0 (step 1, settle 2), dut1 (step 2, settle 2), dut2 (step 1, settle 3).
// A pixel memory models the array; each beat is checked against a queue of
// beats derived from the window/step rules.
module tb_pixel_array_readout;
    import pixel_array_readout_pkg::*;

    typedef logic [12:0] beat_t;  // {last, row[1:0], col[1:0], data[7:0]}

    logic clk = 1'b0;
    logic reset;
    logic start0, start1, start2;
    logic [1:0] row_first, row_last;
    logic [3:0] read0, read1, read2;
    logic [3:0][7:0] bus0, bus1, bus2;
    logic busy0, busy1, busy2, done0, done1, done2;
    readout_state_t state0, state1, state2;
    logic ready;
    int   ready_mode;

    logic [7:0] mem [4][4];
    beat_t exp_q0[$];
    beat_t exp_q1[$];
    beat_t exp_q2[$];
    logic [3:0] read_seq1[$];
    logic [3:0] prev_read1;
    int   done_cnt0, done_cnt1, done_cnt2;
    logic hold0;
    beat_t held_beat0;
    int   vectors, miscompares;

    pixel_array_readout_if #(.BITS(8), .ROW_W(2), .COL_W(2)) if0 ();
    pixel_array_readout_if #(.BITS(8), .ROW_W(2), .COL_W(2)) if1 ();
    pixel_array_readout_if #(.BITS(8), .ROW_W(2), .COL_W(2)) if2 ();

    assign if0.ready = ready;
    assign if1.ready = ready;
    assign if2.ready = ready;

    pixel_array_readout #(.HEIGHT(4), .WIDTH(4), .BITS(8), .SETTLE_CYCLES(2), .ROW_STEP(1)) u_dut0 (
        .clk(clk), .reset(reset), .start(start0), .row_first(row_first), .row_last(row_last),
        .read(read0), .data_in(bus0), .pix(if0), .busy(busy0), .done(done0), .state_dbg(state0));
    pixel_array_readout #(.HEIGHT(4), .WIDTH(4), .BITS(8), .SETTLE_CYCLES(2), .ROW_STEP(2)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .row_first(row_first), .row_last(row_last),
        .read(read1), .data_in(bus1), .pix(if1), .busy(busy1), .done(done1), .state_dbg(state1));
    pixel_array_readout #(.HEIGHT(4), .WIDTH(4), .BITS(8), .SETTLE_CYCLES(3), .ROW_STEP(1)) u_dut2 (
        .clk(clk), .reset(reset), .start(start2), .row_first(row_first), .row_last(row_last),
        .read(read2), .data_in(bus2), .pix(if2), .busy(busy2), .done(done2), .state_dbg(state2));

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- array model ----------------
    function automatic logic [3:0][7:0] row_bus(input logic [3:0] rd);
        logic [3:0][7:0] b;
        for (int c = 0; c < 4; c++) b[c] = 8'hEE;
        for (int r = 0; r < 4; r++) begin
            if (rd == (4'b0001 << r)) begin
                for (int c = 0; c < 4; c++) b[c] = mem[r][c];
            end
        end
        return b;
    endfunction

    always @(negedge clk) begin
        bus0 = row_bus(read0);
        bus1 = row_bus(read1);
        bus2 = row_bus(read2);
    end

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       ready = 1'b0;
            1:       ready = 1'b1;
            2:       ready = ~ready;
            default: ready = 1'($urandom_range(0, 1));
        endcase
    end

    // ---------------- check helper ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboards ----------------
    always @(negedge clk) begin
        if (reset) begin
            hold0 = 1'b0;
        end else begin
            if (done0) done_cnt0++;
            check("dut0_read_onehot", 32'($onehot0(read0)), 1);
            if (hold0) begin
                check("dut0_hold_valid", if0.valid, 1);
                check("dut0_hold_beat", {if0.last, if0.row, if0.col, if0.data}, held_beat0);
            end
            hold0 = if0.valid && !if0.ready;
            held_beat0 = {if0.last, if0.row, if0.col, if0.data};
            if (if0.valid && if0.ready) begin
                if (exp_q0.size() == 0) check("dut0_extra_beat", exp_q0.size(), 1);
                else check("dut0_beat", {if0.last, if0.row, if0.col, if0.data}, exp_q0.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (done1) done_cnt1++;
            check("dut1_read_onehot", 32'($onehot0(read1)), 1);
            if (read1 != prev_read1 && read1 != 4'b0) read_seq1.push_back(read1);
            prev_read1 = read1;
            if (if1.valid && if1.ready) begin
                if (exp_q1.size() == 0) check("dut1_extra_beat", exp_q1.size(), 1);
                else check("dut1_beat", {if1.last, if1.row, if1.col, if1.data}, exp_q1.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (done2) done_cnt2++;
            check("dut2_read_onehot", 32'($onehot0(read2)), 1);
            if (if2.valid && if2.ready) begin
                if (exp_q2.size() == 0) check("dut2_extra_beat", exp_q2.size(), 1);
                else check("dut2_beat", {if2.last, if2.row, if2.col, if2.data}, exp_q2.pop_front());
            end
        end
    end

    // ---------------- reference model ----------------
    task automatic fill_mem(input bit ramp);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                mem[r][c] = ramp ? 8'(r * 16 + c) : 8'($urandom_range(0, 255));
    endtask

    task automatic expect_frame(input int k, input int first, input int last, input int step);
        int rows[$];
        beat_t b;
        int lst;
        lst = (last > 3) ? 3 : last;
        for (int r = first; r <= lst; r += step) rows.push_back(r);
        for (int i = 0; i < rows.size(); i++) begin
            for (int c = 0; c < 4; c++) begin
                b = {(i == rows.size() - 1) && (c == 3), 2'(rows[i]), 2'(c), mem[rows[i]][c]};
                case (k)
                    0:       exp_q0.push_back(b);
                    1:       exp_q1.push_back(b);
                    default: exp_q2.push_back(b);
                endcase
            end
        end
    endtask

    // ---------------- drivers ----------------
    task automatic pulse_start(input int k, input int f, input int l);
        @(posedge clk); #1;
        row_first = 2'(f);
        row_last  = 2'(l);
        case (k)
            0:       start0 = 1'b1;
            1:       start1 = 1'b1;
            default: start2 = 1'b1;
        endcase
        @(posedge clk); #1;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    endtask

    task automatic measure_valid(input int k, input int budget, output int n);
        logic v;
        n = 0;
        v = 1'b0;
        while (!v && n < budget) begin
            @(posedge clk); #1;
            n++;
            case (k)
                0:       v = if0.valid;
                1:       v = if1.valid;
                default: v = if2.valid;
            endcase
        end
    endtask

    task automatic wait_done(input int k, input int budget, input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            case (k)
                0:       seen = done0;
                1:       seen = done1;
                default: seen = done2;
            endcase
        end
        check(tag, seen, 1);
        @(posedge clk); #1;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int n, d, f, l;
        vectors = 0; miscompares = 0;
        done_cnt0 = 0; done_cnt1 = 0; done_cnt2 = 0;
        hold0 = 1'b0; prev_read1 = 4'b0;
        reset = 1'b1; start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        row_first = 2'd0; row_last = 2'd0; ready = 1'b1; ready_mode = 1;
        fill_mem(1);
        repeat (3) @(posedge clk);
        #1;

        // reset state
        check("rst_read0", read0, 0);
        check("rst_valid0", if0.valid, 0);
        check("rst_data0", if0.data, 0);
        check("rst_row0", if0.row, 0);
        check("rst_col0", if0.col, 0);
        check("rst_last0", if0.last, 0);
        check("rst_busy0", busy0, 0);
        check("rst_done0", done0, 0);
        check("rst_state0", state0, IDLE);
        check("rst_read1", read1, 0);
        check("rst_read2", read2, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // 1: full frame, ramp data, ready high
        expect_frame(0, 0, 3, 1);
        d = done_cnt0;
        pulse_start(0, 0, 3);
        check("t1_busy", busy0, 1);
        measure_valid(0, 20, n);
        check("t1_latency", n, 4);
        wait_done(0, 400, "t1_done");
        check("t1_done_count", done_cnt0 - d, 1);
        check("t1_queue_empty", exp_q0.size(), 0);
        check("t1_busy_after", busy0, 0);

        // 2: window 1..2, ready toggling
        fill_mem(0);
        ready_mode = 2;
        expect_frame(0, 1, 2, 1);
        pulse_start(0, 1, 2);
        wait_done(0, 400, "t2_done");
        check("t2_queue_empty", exp_q0.size(), 0);
        ready_mode = 1;

        // 3: step 2 instance, window 0..3
        fill_mem(1);
        read_seq1.delete();
        expect_frame(1, 0, 3, 2);
        pulse_start(1, 0, 3);
        wait_done(1, 400, "t3_done");
        check("t3_queue_empty", exp_q1.size(), 0);
        check("t3_read_steps", read_seq1.size(), 2);
        if (read_seq1.size() == 2) begin
            check("t3_read_first", read_seq1[0], 4'b0001);
            check("t3_read_second", read_seq1[1], 4'b0100);
        end

        // 4: empty window
        d = done_cnt0;
        pulse_start(0, 3, 1);
        check("t4_busy", busy0, 1);
        @(posedge clk); #1;
        check("t4_done_early", done0, 0);
        check("t4_read_c1", read0, 0);
        check("t4_valid_c1", if0.valid, 0);
        @(posedge clk); #1;
        check("t4_done_at_2", done0, 1);
        check("t4_busy_low", busy0, 0);
        check("t4_read_c2", read0, 0);
        @(posedge clk); #1;
        check("t4_done_pulse", done0, 0);
        check("t4_done_count", done_cnt0 - d, 1);

        // stall with ready low indefinitely
        ready_mode = 0;
        expect_frame(0, 2, 2, 1);
        pulse_start(0, 2, 2);
        repeat (40) @(posedge clk);
        #1;
        check("stall_valid", if0.valid, 1);
        check("stall_read", read0, 0);
        check("stall_col", if0.col, 0);
        check("stall_state", state0, STREAM);
        ready_mode = 1;
        wait_done(0, 400, "stall_done");
        check("stall_queue_empty", exp_q0.size(), 0);

        // 5: reset during row 1
        fill_mem(0);
        expect_frame(0, 0, 3, 1);
        pulse_start(0, 0, 3);
        n = 0;
        while (!(if0.valid && if0.row == 2'd1) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("t5_reached_row1", 32'(if0.valid && if0.row == 2'd1), 1);
        d = done_cnt0;
        reset = 1'b1;
        exp_q0.delete();
        @(posedge clk); #1;
        check("t5_read", read0, 0);
        check("t5_valid", if0.valid, 0);
        check("t5_busy", busy0, 0);
        check("t5_done", done0, 0);
        check("t5_state", state0, IDLE);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("t5_no_done", done_cnt0 - d, 0);
        fill_mem(0);
        expect_frame(0, 0, 3, 1);
        pulse_start(0, 0, 3);
        wait_done(0, 400, "t5_refill_done");
        check("t5_queue_empty", exp_q0.size(), 0);

        // 6: settle 3 instance, start ignored while busy
        fill_mem(0);
        expect_frame(2, 0, 3, 1);
        d = done_cnt2;
        pulse_start(2, 0, 3);
        measure_valid(2, 20, n);
        check("t6_latency", n, 5);
        repeat (3) @(posedge clk);
        pulse_start(2, 1, 1);
        wait_done(2, 400, "t6_done");
        check("t6_queue_empty", exp_q2.size(), 0);
        repeat (10) @(posedge clk);
        #1;
        check("t6_not_restarted", busy2, 0);
        check("t6_done_count", done_cnt2 - d, 1);

        // random frames with random ready
        ready_mode = 3;
        for (int i = 0; i < 4; i++) begin
            fill_mem(0);
            f = $urandom_range(0, 3);
            l = $urandom_range(0, 3);
            expect_frame(0, f, l, 1);
            pulse_start(0, f, l);
            wait_done(0, 600, "rand0_done");
            check("rand0_queue_empty", exp_q0.size(), 0);
        end
        for (int i = 0; i < 2; i++) begin
            fill_mem(0);
            f = $urandom_range(0, 3);
            l = $urandom_range(0, 3);
            expect_frame(1, f, l, 2);
            pulse_start(1, f, l);
            wait_done(1, 600, "rand1_done");
            check("rand1_queue_empty", exp_q1.size(), 0);
        end
        ready_mode = 1;

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
